// File: rtl/multicycle_main_controller.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction,
// drives datapath mux selects/enables and aluop, and bounds waits on mem_ready.
module multicycle_main_controller #(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       iord_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       regwrite_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsrc_o,
  output logic [1:0] aluop_o,
  output logic       pcen_o,
  output logic       illegal_op_o,
  output logic       mem_timeout_o
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_st, timeout, pcwrite, branch;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore output decode; memory-dependent enables gated by mem_ready
  always_comb begin
    state_d       = state_q;
    iord_o        = 1'b0;
    memwrite_o    = 1'b0;
    irwrite_o     = 1'b0;
    regdst_o      = 1'b0;
    memtoreg_o    = 1'b0;
    regwrite_o    = 1'b0;
    alusrca_o     = 1'b0;
    alusrcb_o     = 2'b00;
    pcsrc_o       = 2'b00;
    aluop_o       = 2'b00;
    illegal_op_o  = 1'b0;
    pcwrite       = 1'b0;
    branch        = 1'b0;
    wait_st       = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout       = wait_st && !mem_ready_i && (cnt_q == CNT_LAST);
    mem_timeout_o = timeout;
    cnt_d         = (wait_st && !mem_ready_i && !timeout) ? cnt_q + CNT_W'(1) : '0;

    case (state_q)
      S_FETCH: begin
        alusrcb_o = 2'b01;
        irwrite_o = mem_ready_i;
        pcwrite   = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_o = 2'b11;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal_op_o = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        state_d   = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_o = 1'b1;
        if (mem_ready_i)  state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWB: begin
        memtoreg_o = 1'b1;
        regwrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord_o     = 1'b1;
        memwrite_o = !timeout;
        if (mem_ready_i || timeout) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_o = 1'b1;
        aluop_o   = 2'b10;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst_o   = 1'b1;
        regwrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQEX: begin
        alusrca_o = 1'b1;
        aluop_o   = 2'b01;
        pcsrc_o   = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc_o = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    pcen_o = pcwrite | (branch & zero_i);

    // Reset forces a fully quiet datapath regardless of state
    if (reset_i) begin
      iord_o        = 1'b0;
      memwrite_o    = 1'b0;
      irwrite_o     = 1'b0;
      regdst_o      = 1'b0;
      memtoreg_o    = 1'b0;
      regwrite_o    = 1'b0;
      alusrca_o     = 1'b0;
      alusrcb_o     = 2'b00;
      pcsrc_o       = 2'b00;
      aluop_o       = 2'b00;
      pcen_o        = 1'b0;
      illegal_op_o  = 1'b0;
      mem_timeout_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller: per-cycle output vectors against hand-built values.
module tb_multicycle_main_controller;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] op;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       pcen, illegal_op, mem_timeout;

  int checks = 0;
  int errors = 0;

  // Vector layout: {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca, alusrcb, pcsrc, aluop, pcen,illegal_op,mem_timeout}
  localparam logic [15:0] E_RST  = 16'h0000;
  localparam logic [15:0] E_FET  = {7'b0010000, 2'b01, 2'b00, 2'b00, 3'b100};
  localparam logic [15:0] E_FWT  = {7'b0000000, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_FTO  = {7'b0000000, 2'b01, 2'b00, 2'b00, 3'b001};
  localparam logic [15:0] E_DEC  = {7'b0000000, 2'b11, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_ILL  = {7'b0000000, 2'b11, 2'b00, 2'b00, 3'b010};
  localparam logic [15:0] E_REX  = {7'b0000001, 2'b00, 2'b00, 2'b10, 3'b000};
  localparam logic [15:0] E_RWB  = {7'b0001010, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_MADR = {7'b0000001, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_MRD  = {7'b1000000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_MWB  = {7'b0000110, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_MWR  = {7'b1100000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_MWTO = {7'b1000000, 2'b00, 2'b00, 2'b00, 3'b001};
  localparam logic [15:0] E_BQ1  = {7'b0000001, 2'b00, 2'b01, 2'b01, 3'b100};
  localparam logic [15:0] E_BQ0  = {7'b0000001, 2'b00, 2'b01, 2'b01, 3'b000};
  localparam logic [15:0] E_AEX  = {7'b0000001, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_AWB  = {7'b0000010, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [15:0] E_JEX  = {7'b0000000, 2'b00, 2'b10, 2'b00, 3'b100};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  multicycle_main_controller #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
    .clk_i(clk), .reset_i(reset), .op_i(op), .zero_i(zero), .mem_ready_i(mem_ready),
    .iord_o(iord), .memwrite_o(memwrite), .irwrite_o(irwrite), .regdst_o(regdst),
    .memtoreg_o(memtoreg), .regwrite_o(regwrite), .alusrca_o(alusrca), .alusrcb_o(alusrcb),
    .pcsrc_o(pcsrc), .aluop_o(aluop), .pcen_o(pcen), .illegal_op_o(illegal_op),
    .mem_timeout_o(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, sample outputs mid-cycle, then advance past the next edge
  task automatic cyc(input string tag, input logic rst, input logic mr, input logic z,
                     input logic [5:0] o, input logic [15:0] exp);
    reset = rst; mem_ready = mr; zero = z; op = o;
    @(negedge clk);
    check(tag, {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, aluop, pcen, illegal_op, mem_timeout}, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = OP_R;
    #1;
    for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 1'b1, 1'b0, OP_R, E_RST);

    // R-type: back in FETCH on cycle 5
    cyc("r_fetch",  1'b0, 1'b1, 1'b0, OP_R, E_FET);
    cyc("r_decode", 1'b0, 1'b1, 1'b0, OP_R, E_DEC);
    cyc("r_ex",     1'b0, 1'b1, 1'b0, OP_R, E_REX);
    cyc("r_wb",     1'b0, 1'b1, 1'b0, OP_R, E_RWB);

    // lw with three wait cycles; ready on the limit cycle advances normally
    cyc("lw_fetch",  1'b0, 1'b1, 1'b0, OP_LW, E_FET);
    cyc("lw_decode", 1'b0, 1'b1, 1'b0, OP_LW, E_DEC);
    cyc("lw_adr",    1'b0, 1'b1, 1'b0, OP_LW, E_MADR);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 1'b0, 1'b0, 1'b0, OP_LW, E_MRD);
    cyc("lw_rd_done", 1'b0, 1'b1, 1'b0, OP_LW, E_MRD);
    cyc("lw_wb",      1'b0, 1'b1, 1'b0, OP_LW, E_MWB);

    // beq taken then not taken
    cyc("beq1_fetch",  1'b0, 1'b1, 1'b1, OP_BEQ, E_FET);
    cyc("beq1_decode", 1'b0, 1'b1, 1'b1, OP_BEQ, E_DEC);
    cyc("beq1_ex",     1'b0, 1'b1, 1'b1, OP_BEQ, E_BQ1);
    cyc("beq0_fetch",  1'b0, 1'b1, 1'b0, OP_BEQ, E_FET);
    cyc("beq0_decode", 1'b0, 1'b1, 1'b0, OP_BEQ, E_DEC);
    cyc("beq0_ex",     1'b0, 1'b1, 1'b0, OP_BEQ, E_BQ0);

    // illegal opcode
    cyc("ill_fetch",  1'b0, 1'b1, 1'b0, OP_BAD, E_FET);
    cyc("ill_decode", 1'b0, 1'b1, 1'b0, OP_BAD, E_ILL);

    // sw that times out in MEMWR
    cyc("sw_fetch",  1'b0, 1'b1, 1'b0, OP_SW, E_FET);
    cyc("sw_decode", 1'b0, 1'b1, 1'b0, OP_SW, E_DEC);
    cyc("sw_adr",    1'b0, 1'b1, 1'b0, OP_SW, E_MADR);
    for (int i = 0; i < 3; i++) cyc("sw_wr_wait", 1'b0, 1'b0, 1'b0, OP_SW, E_MWR);
    cyc("sw_timeout", 1'b0, 1'b0, 1'b0, OP_SW, E_MWTO);

    // addi then j
    cyc("addi_fetch",  1'b0, 1'b1, 1'b0, OP_ADDI, E_FET);
    cyc("addi_decode", 1'b0, 1'b1, 1'b0, OP_ADDI, E_DEC);
    cyc("addi_ex",     1'b0, 1'b1, 1'b0, OP_ADDI, E_AEX);
    cyc("addi_wb",     1'b0, 1'b1, 1'b0, OP_ADDI, E_AWB);
    cyc("j_fetch",     1'b0, 1'b1, 1'b0, OP_J, E_FET);
    cyc("j_decode",    1'b0, 1'b1, 1'b0, OP_J, E_DEC);
    cyc("j_ex",        1'b0, 1'b1, 1'b0, OP_J, E_JEX);

    // FETCH timeout retries FETCH, then a normal fetch succeeds
    for (int i = 0; i < 3; i++) cyc("fetch_wait", 1'b0, 1'b0, 1'b0, OP_R, E_FWT);
    cyc("fetch_timeout", 1'b0, 1'b0, 1'b0, OP_R, E_FTO);
    cyc("fetch_retry",   1'b0, 1'b0, 1'b0, OP_R, E_FWT);
    cyc("fetch_ok",      1'b0, 1'b1, 1'b0, OP_R, E_FET);
    cyc("r2_decode",     1'b0, 1'b1, 1'b0, OP_R, E_DEC);

    // reset asserted while in RTYPEEX aborts the instruction
    cyc("mid_reset",   1'b1, 1'b1, 1'b0, OP_R, E_RST);
    cyc("post_reset",  1'b0, 1'b1, 1'b0, OP_R, E_FET);
    cyc("post_decode", 1'b0, 1'b1, 1'b0, OP_R, E_DEC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
